// File: rtl/rr_grant_pkg.sv
// Shared types and helpers for the round-robin grant scheduler and related arbiters.
// Optional concurrent checks in rr_grant_sched are enabled with RR_GRANT_SVA_EN.
package rr_grant_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ_DEF = 4;

  // Requester index at the default arbiter width.
  typedef logic [$clog2(N_REQ_DEF)-1:0] req_idx_t;

  // Longest a held request can wait for its grant: every other requester
  // may hold for a full budget plus its gap cycle first.
  function automatic int wait_max(input int n_req, input int max_hold);
    return 1 + (n_req - 1) * (max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: finds the first set req bit at or above rr_ptr,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick
  import rr_grant_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;
  logic [IDX_W:0]     idx_sum;

  // Doubling the vector turns the wrap-around search into a plain shift.
  assign req_dbl = {req, req};
  assign req_rot = N_REQ'(req_dbl >> rr_ptr);
  assign any     = |req;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = IDX_W'(k);
    end
    idx_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (idx_sum >= (IDX_W+1)'(N_REQ)) winner = IDX_W'(idx_sum - (IDX_W+1)'(N_REQ));
    else                              winner = idx_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler with req/gnt hold handshake and MAX_HOLD forced release.
// Define RR_GRANT_SVA_EN to compile in concurrent protocol assertions.
module rr_grant_sched
  import rr_grant_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_vld,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     preempt
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [IDX_W-1:0]   gnt_id_d;
  logic               preempt_d;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_w;
  logic               owner_req;
  logic               hold_full;
  logic [IDX_W-1:0]   next_ptr;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .winner (pick_w)
  );

  // gnt_id is zero outside GRANT, so these are only meaningful while granting.
  assign owner_req = req[gnt_id];
  assign hold_full = (hold_q == HOLD_W'(MAX_HOLD));
  assign next_ptr  = (gnt_id == IDX_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking assignments here would create races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      preempt  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      gnt      <= gnt_d;
      gnt_vld  <= |gnt_d;
      gnt_id   <= gnt_id_d;
      preempt  <= preempt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   if (!owner_req || hold_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Any release returns to IDLE with gnt cleared, which yields the gap cycle.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    hold_d    = '0;
    rr_ptr_d  = rr_ptr_q;
    preempt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d    = N_REQ'(1) << pick_w;
          gnt_id_d = pick_w;
          hold_d   = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req) begin
          rr_ptr_d = next_ptr;
        end else if (hold_full) begin
          rr_ptr_d  = next_ptr;
          preempt_d = 1'b1;
        end else begin
          gnt_d    = gnt;
          gnt_id_d = gnt_id;
          hold_d   = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef RR_GRANT_SVA_EN
  localparam int WAIT_MAX = wait_max(N_REQ, MAX_HOLD);

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("%m: gnt is not one-hot-or-zero");

  a_vld_matches: assert property (@(posedge clk) disable iff (rst) gnt_vld == |gnt)
    else $error("%m: gnt_vld differs from OR of gnt");

  a_preempt_gap: assert property (@(posedge clk) disable iff (rst) preempt |-> !gnt_vld)
    else $error("%m: preempt raised while a grant is valid");

  for (genvar i = 0; i < N_REQ; i++) begin : g_req_sva
    a_gnt_had_req: assert property (@(posedge clk) disable iff (rst) gnt[i] |-> $past(req[i]))
      else $error("%m: grant %0d without prior request", i);

    // A request that drops before service ends the obligation.
    a_bounded_wait: assert property (@(posedge clk) disable iff (rst)
      (req[i] && !gnt[i]) |-> s_eventually [1:WAIT_MAX] (gnt[i] || !req[i]))
      else $error("%m: request %0d not granted within bound", i);
  end
`endif

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed plus randomized bench for rr_grant_sched; expectations flow through a scoreboard queue.
module tb_rr_grant_sched;
  import rr_grant_pkg::*;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = wait_max(N_REQ, MAX_HOLD);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_vld;
  req_idx_t   gnt_id;
  logic       preempt;

  typedef struct {
    logic [3:0] gnt;
    logic       vld;
    req_idx_t   id;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_grant_sched #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .preempt (preempt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_idx_t idx_of(input logic [3:0] oh);
    idx_of = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) idx_of = req_idx_t'(i);
  endfunction

  task automatic expect_next(input logic [3:0] eg, input logic ep, input string tag);
    exp_t e;
    e.gnt = eg;
    e.vld = |eg;
    e.id  = idx_of(eg);
    e.pre = ep;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".gnt"},     gnt,     e.gnt);
      check({e.tag, ".gnt_vld"}, gnt_vld, e.vld);
      check({e.tag, ".gnt_id"},  gnt_id,  e.id);
      check({e.tag, ".preempt"}, preempt, e.pre);
    end
  endtask

  // Drive req for one cycle; the outputs of the following cycle are checked.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic ep, input string tag);
    @(negedge clk);
    req = r;
    expect_next(eg, ep, tag);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] rq;
  logic [3:0] was_g;
  int         use_left[4];
  int         start[4];
  int         max_wait;
  int         overdue;
  int         grants;

  initial begin
    logic [3:0] eg;
    int         n;

    rst = 1'b1;
    req = '0;
    #1;
    check("reset.gnt",     gnt,     0);
    check("reset.gnt_vld", gnt_vld, 0);
    check("reset.gnt_id",  gnt_id,  0);
    check("reset.preempt", preempt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester: grant in cycles 1-3, released in cycle 4.
    step(4'b0100, 4'b0100, 1'b0, "single.c1");
    step(4'b0100, 4'b0100, 1'b0, "single.c2");
    step(4'b0100, 4'b0100, 1'b0, "single.c3");
    step(4'b0000, 4'b0000, 1'b0, "single.c4");
    step(4'b0000, 4'b0000, 1'b0, "single.c5");

    // All requesting: 8-cycle grants separated by a preempt gap, rotating 0..3.
    do_reset();
    for (int c = 0; c < 37; c++) begin
      n  = c + 1;
      eg = ((n - 1) % 9 < 8) ? (4'b0001 << (((n - 1) / 9) % 4)) : 4'b0000;
      step(4'b1111, eg, ((n - 1) % 9) == 8, "rotate");
    end
    step(4'b0000, 4'b0000, 1'b0, "rotate.release");

    // Pointer fairness after releases of 3 and then 0.
    step(4'b1000, 4'b1000, 1'b0, "fair.g3");
    step(4'b0000, 4'b0000, 1'b0, "fair.rel3");
    step(4'b1001, 4'b0001, 1'b0, "fair.g0");
    step(4'b0000, 4'b0000, 1'b0, "fair.rel0");
    step(4'b1001, 4'b1000, 1'b0, "fair.g3b");
    step(4'b0000, 4'b0000, 1'b0, "fair.rel3b");

    // req[1] drops as req[2] rises; req[1] returns in the gap but loses to 2.
    step(4'b0010, 4'b0010, 1'b0, "coll.g1");
    step(4'b0010, 4'b0010, 1'b0, "coll.g1b");
    step(4'b0100, 4'b0000, 1'b0, "coll.gap");
    step(4'b0110, 4'b0100, 1'b0, "coll.g2");
    step(4'b0010, 4'b0000, 1'b0, "coll.rel2");
    step(4'b0010, 4'b0010, 1'b0, "coll.g1c");
    step(4'b0000, 4'b0000, 1'b0, "coll.rel1");

    // Async reset while gnt[3] is held at hold_cnt=5.
    for (int c = 0; c < 5; c++) step(4'b1000, 4'b1000, 1'b0, "arst.hold");
    #2;
    rst = 1'b1;
    #1;
    check("arst.gnt",     gnt,     0);
    check("arst.gnt_vld", gnt_vld, 0);
    check("arst.gnt_id",  gnt_id,  0);
    check("arst.preempt", preempt, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_next(4'b1000, 1'b0, "arst.regrant");
    @(posedge clk);
    #1;
    compare_out();
    for (int c = 0; c < 7; c++) step(4'b1000, 4'b1000, 1'b0, "arst.budget");
    step(4'b1000, 4'b0000, 1'b1, "arst.preempt");
    step(4'b0000, 4'b0000, 1'b0, "arst.idle");

    // Random held requests: mutual exclusion and bounded wait.
    do_reset();
    rq = '0;
    was_g = '0;
    max_wait = 0;
    overdue = 0;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      use_left[i] = 0;
      start[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && use_left[i] == 0) begin
          rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
          use_left[i] = $urandom_range(1, 12);
          start[i] = cyc;
        end
      end
      req = rq;
      @(posedge clk);
      #1;
      check("rnd.onehot0", $onehot0(gnt), 1);
      check("rnd.preempt_gap", preempt & gnt_vld, 0);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if (!was_g[i]) begin
            grants++;
            if (cyc + 1 - start[i] > max_wait) max_wait = cyc + 1 - start[i];
          end
          if (use_left[i] > 0) use_left[i]--;
        end else if (rq[i]) begin
          if (was_g[i]) start[i] = cyc + 1;
          if (cyc + 1 - start[i] > WAIT_MAX) overdue++;
        end
      end
      was_g = gnt;
    end
    req = '0;
    check("rnd.max_wait_bound", max_wait <= WAIT_MAX, 1);
    check("rnd.overdue", overdue, 0);
    check("rnd.grants_seen", grants > 100, 1);
    check("sb.drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
